// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and helpers for the data-memory miss controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int unsigned c_line_bytes = 16;
    localparam int unsigned c_l2_latency = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        L2_LOOKUP = 3'd1,
        MEM_WAIT  = 3'd2,
        L2_FILL   = 3'd3,
        L1_FILL   = 3'd4,
        WR_THRU   = 3'd5,
        DONE      = 3'd6
    } miss_state_e;

    // Clears the byte-offset bits; line_bytes must be a power of two.
    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_latency_timer.sv
`default_nettype none
// ============================================================================
// Module      : cache_latency_timer
// Description : Loadable down-counter with zero flag for L2 lookup/write-through.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_latency_timer
    import cache_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_controller
// Description : Miss-handling FSM between the M-stage port, L1/L2 and memory.
//               Optional perf counters enabled by defining CACHE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_miss_controller
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = c_line_bytes,
    parameter int unsigned L2_LATENCY = c_l2_latency
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              l1_hit,
    input  logic              l2_hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              l2_fill_en,
    output logic              l1_fill_en,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              mem_stall,
    output logic              l1_miss,
    output logic              l2_miss,
    output logic              cache_busy,
    output logic [31:0]       perf_l1_miss_cnt,
    output logic [31:0]       perf_l2_miss_cnt,
    output logic [31:0]       perf_stall_cnt
);

    localparam int unsigned c_cnt_w = $clog2(L2_LATENCY + 1);

    miss_state_e       r_state;
    miss_state_e       w_next_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic              w_timer_load;
    logic              w_timer_dec;
    logic              w_timer_zero;
    logic              w_idle_req;
    logic [ADDR_W-1:0] w_line_addr;

    // IDLE outputs follow the request combinationally; gating with rst_n keeps
    // every stall cause low while reset is asserted.
    assign w_idle_req   = (r_state == IDLE) && req_valid && rst_n;
    assign w_timer_load = w_idle_req && (req_write || !l1_hit);
    assign w_timer_dec  = (r_state == L2_LOOKUP) || (r_state == WR_THRU);

    cache_latency_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_timer_load),
        .load_val (c_cnt_w'(L2_LATENCY - 1)),
        .dec      (w_timer_dec),
        .zero     (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_addr_q <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_timer_load) begin
                r_addr_q <= req_addr;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        l2_fill_en   = 1'b0;
        l1_fill_en   = 1'b0;
        l1_miss      = 1'b0;
        l2_miss      = 1'b0;
        cache_busy   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_idle_req) begin
                    if (req_write) begin
                        cache_busy   = 1'b1;
                        w_next_state = WR_THRU;
                    end else if (!l1_hit) begin
                        l1_miss      = 1'b1;
                        w_next_state = L2_LOOKUP;
                    end
                end
            end
            L2_LOOKUP: begin
                l1_miss = 1'b1;
                if (w_timer_zero) begin
                    w_next_state = l2_hit ? L1_FILL : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                l2_miss = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next_state = L2_FILL;
                end
            end
            L2_FILL: begin
                cache_busy   = 1'b1;
                l2_fill_en   = 1'b1;
                w_next_state = L1_FILL;
            end
            L1_FILL: begin
                cache_busy   = 1'b1;
                l1_fill_en   = 1'b1;
                w_next_state = DONE;
            end
            WR_THRU: begin
                cache_busy = 1'b1;
                if (w_timer_zero) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem_stall   = l1_miss || l2_miss || cache_busy;
    assign w_line_addr = ADDR_W'(line_align(64'(r_addr_q), LINE_BYTES));
    assign mem_addr    = w_line_addr;
    assign fill_addr   = w_line_addr;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] r_perf_l1_miss_cnt;
    logic [31:0] r_perf_l2_miss_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_l1_miss_cnt <= '0;
            r_perf_l2_miss_cnt <= '0;
            r_perf_stall_cnt   <= '0;
        end else begin
            if ((r_state == IDLE) && (w_next_state == L2_LOOKUP)
                && (r_perf_l1_miss_cnt != '1)) begin
                r_perf_l1_miss_cnt <= r_perf_l1_miss_cnt + 32'd1;
            end
            if ((r_state == L2_LOOKUP) && (w_next_state == MEM_WAIT)
                && (r_perf_l2_miss_cnt != '1)) begin
                r_perf_l2_miss_cnt <= r_perf_l2_miss_cnt + 32'd1;
            end
            if (mem_stall && (r_perf_stall_cnt != '1)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_l1_miss_cnt = r_perf_l1_miss_cnt;
    assign perf_l2_miss_cnt = r_perf_l2_miss_cnt;
    assign perf_stall_cnt   = r_perf_stall_cnt;
`else
    assign perf_l1_miss_cnt = '0;
    assign perf_l2_miss_cnt = '0;
    assign perf_stall_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_miss_controller
// Description : Self-checking bench: directed scenarios then random requests
//               against a phase-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_miss_controller;

    localparam int unsigned c_addr_w = 32;
    localparam int unsigned c_line   = 16;
    localparam int          c_lat    = 4;

    // Expected flag vector: {mem_req, l2_fill_en, l1_fill_en, mem_stall, l1_miss, l2_miss, cache_busy}
    localparam logic [6:0] c_e_none = 7'b0000000;
    localparam logic [6:0] c_e_l1m  = 7'b0001100;
    localparam logic [6:0] c_e_l2m  = 7'b1001010;
    localparam logic [6:0] c_e_busy = 7'b0001001;
    localparam logic [6:0] c_e_l2f  = 7'b0101001;
    localparam logic [6:0] c_e_l1f  = 7'b0011001;

    localparam int c_k_hit   = 0;
    localparam int c_k_l2hit = 1;
    localparam int c_k_l2mis = 2;
    localparam int c_k_store = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_write = 1'b0;
    logic [c_addr_w-1:0] req_addr = '0;
    logic                l1_hit = 1'b0;
    logic                l2_hit = 1'b0;
    logic                mem_ack = 1'b0;
    logic                mem_req, l2_fill_en, l1_fill_en;
    logic                mem_stall, l1_miss, l2_miss, cache_busy;
    logic [c_addr_w-1:0] mem_addr, fill_addr;
    logic [31:0]         perf_l1_miss_cnt, perf_l2_miss_cnt, perf_stall_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_addr_q = '0;
    logic [31:0] m_l1cnt = '0;
    logic [31:0] m_l2cnt = '0;
    logic [31:0] m_stall = '0;

    cache_miss_controller #(
        .ADDR_W     (c_addr_w),
        .LINE_BYTES (c_line),
        .L2_LATENCY (c_lat)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .l1_hit           (l1_hit),
        .l2_hit           (l2_hit),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .l2_fill_en       (l2_fill_en),
        .l1_fill_en       (l1_fill_en),
        .fill_addr        (fill_addr),
        .mem_stall        (mem_stall),
        .l1_miss          (l1_miss),
        .l2_miss          (l2_miss),
        .cache_busy       (cache_busy),
        .perf_l1_miss_cnt (perf_l1_miss_cnt),
        .perf_l2_miss_cnt (perf_l2_miss_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] exp_flags);
        logic [31:0] line;
        line = m_addr_q & ~(c_line - 1);
        check({tag, "/flags"}, 64'({mem_req, l2_fill_en, l1_fill_en, mem_stall,
                                    l1_miss, l2_miss, cache_busy}), 64'(exp_flags));
        check({tag, "/mem_addr"}, 64'(mem_addr), 64'(line));
        check({tag, "/fill_addr"}, 64'(fill_addr), 64'(line));
`ifdef CACHE_PERF_CNT_EN
        check({tag, "/perf"}, {perf_l1_miss_cnt, perf_l2_miss_cnt},
              {m_l1cnt, m_l2cnt});
        check({tag, "/perf_stall"}, 64'(perf_stall_cnt), 64'(m_stall));
`else
        check({tag, "/perf"}, {perf_l1_miss_cnt, perf_l2_miss_cnt, perf_stall_cnt},
              64'(0));
`endif
    endtask

    task automatic model_reset();
        m_addr_q = '0;
        m_l1cnt  = '0;
        m_l2cnt  = '0;
        m_stall  = '0;
    endtask

    // One cycle with no request: nothing may stall, stray mem_ack is ignored.
    task automatic idle_cycle(input string tag);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        l1_hit    = 1'($urandom);
        l2_hit    = 1'($urandom);
        mem_ack   = 1'($urandom);
        #2 check_all(tag, c_e_none);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one request from IDLE through DONE. Phase lengths: 1 decision
    // cycle, c_lat lookup (or write-through) cycles, d+1 memory-wait cycles,
    // one cycle per fill, one DONE cycle. abort_at >= 0 resets mid-flight.
    task automatic run_txn(input string tag, input int kind, input logic [31:0] addr,
                           input int d, input int abort_at);
        int          n;
        logic [6:0]  e;
        case (kind)
            c_k_hit:   n = 1;
            c_k_l2hit: n = c_lat + 3;
            c_k_l2mis: n = c_lat + d + 5;
            default:   n = c_lat + 2;
        endcase
        for (int i = 0; i < n; i++) begin
            if (kind == c_k_hit || i == n - 1)      e = c_e_none;
            else if (kind == c_k_store)             e = c_e_busy;
            else if (i <= c_lat)                    e = c_e_l1m;
            else if (kind == c_k_l2hit)             e = c_e_l1f;
            else if (i <= c_lat + 1 + d)            e = c_e_l2m;
            else if (i == c_lat + 2 + d)            e = c_e_l2f;
            else                                    e = c_e_l1f;

            if (kind != c_k_hit && i == n - 1) begin
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_addr  = $urandom;
                l1_hit    = 1'($urandom);
            end else begin
                req_valid = 1'b1;
                req_write = (kind == c_k_store);
                req_addr  = addr;
                l1_hit    = (kind == c_k_hit) ? 1'b1 :
                            (kind == c_k_store) ? 1'($urandom) : 1'b0;
            end
            l2_hit  = (i == c_lat) ? (kind == c_k_l2hit) : 1'($urandom);
            mem_ack = (kind == c_k_l2mis && i > c_lat && i <= c_lat + 1 + d) ?
                      (i == c_lat + 1 + d) : 1'($urandom);

            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_all({tag, "/in_reset"}, c_e_none);
                mem_ack = 1'b1;
                @(posedge clk);
                #1 check_all({tag, "/reset_held"}, c_e_none);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            #2 check_all($sformatf("%s/c%0d", tag, i), e);
            @(posedge clk);
            if (e[3] && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (i == 0 && (kind == c_k_l2hit || kind == c_k_l2mis)) m_l1cnt++;
            if (kind == c_k_l2mis && i == c_lat) m_l2cnt++;
            if (i == 0 && kind != c_k_hit) m_addr_q = addr;
            @(negedge clk);
        end
    endtask

    initial begin
        req_valid = 1'b1;
        l1_hit    = 1'b0;
        #2 check_all("reset_async", c_e_none);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle("post_reset");

        run_txn("s1_hit", c_k_hit, 32'h100, 0, -1);
        idle_cycle("s1_idle");
        run_txn("s2_l2hit", c_k_l2hit, 32'h104, 0, -1);
        run_txn("s3_l2miss", c_k_l2mis, 32'h2A8, 10, -1);
        run_txn("s4_store", c_k_store, 32'h40, 0, -1);
        run_txn("s5_abort", c_k_l2mis, 32'h3C4, 8, c_lat + 4);
        for (int k = 0; k < 3; k++) idle_cycle("s5_after");

        run_txn("b_l2miss_ack0", c_k_l2mis, 32'hFFFF_FFFF, 0, -1);
        run_txn("b_back2back", c_k_l2hit, 32'h0000_001F, 0, -1);

        for (int t = 0; t < 40; t++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a    = $urandom;
            run_txn($sformatf("rnd%0d", t), kind, a, $urandom_range(0, 12), -1);
            for (int j = $urandom_range(0, 2); j > 0; j--) idle_cycle("rnd_idle");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
